// File: rtl/sensor_scan_ctrl_pkg.sv
// Shared definitions for the baggage-height sensor scan path: state encoding,
// default sample width and sensor index constants.
package sensor_scan_ctrl_pkg;

  localparam int SENSOR_W_DEF = 8;
  localparam int NUM_SENSORS  = 4;

  localparam logic [1:0] SENSOR1_IDX = 2'd0;
  localparam logic [1:0] SENSOR2_IDX = 2'd1;
  localparam logic [1:0] SENSOR3_IDX = 2'd2;
  localparam logic [1:0] SENSOR4_IDX = 2'd3;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_REQ_ENC   = 3'd1;
  localparam logic [2:0] ST_GAP_ENC   = 3'd2;
  localparam logic [2:0] ST_CALC_ENC  = 3'd3;
  localparam logic [2:0] ST_CHECK_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_REQ   = ST_REQ_ENC,
    ST_GAP   = ST_GAP_ENC,
    ST_CALC  = ST_CALC_ENC,
    ST_CHECK = ST_CHECK_ENC
  } scan_state_e;

endpackage

// File: rtl/sensor_scan_ctrl_if.sv
// Shared ADC request bus: the scan controller drives request/select, the ADC
// front end answers with ack/data.
interface sensor_scan_ctrl_if #(
  parameter int SENSOR_W = 8
);
  logic                adc_req;
  logic [1:0]          adc_sel;
  logic                adc_ack;
  logic [SENSOR_W-1:0] adc_data;

  modport master (output adc_req, output adc_sel, input adc_ack, input adc_data);
  modport slave  (input adc_req, input adc_sel, output adc_ack, output adc_data);
endinterface

// File: rtl/sensor_scan_ctrl_ack_timer.sv
// Saturating wait counter for one ADC request; expired flags that the request
// has been outstanding for ACK_TMO counted cycles.
module scan_ack_timer #(
  parameter int ACK_TMO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int TW = $clog2(ACK_TMO + 1);

  logic [TW-1:0] count_r;

  // Wait counter: clear wins, counts while enabled and sticks at ACK_TMO.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {TW{1'b0}};
    end else if (clear) begin
      count_r <= {TW{1'b0}};
    end else if (enable && (count_r != TW'(ACK_TMO))) begin
      count_r <= count_r + TW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == TW'(ACK_TMO));
endmodule

// File: rtl/sensor_scan_ctrl.sv
// Scans the four height sensors over the shared ADC bus, feeds the height datapath
// and publishes the height once STABLE_CNT consecutive scans agree.
module sensor_scan_ctrl
  import sensor_scan_ctrl_pkg::*;
#(
  parameter int SENSOR_W   = SENSOR_W_DEF,
  parameter int STABLE_CNT = 4,
  parameter int MAX_SCANS  = 16,
  parameter int ACK_TMO    = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  sensor_scan_ctrl_if.master  adc,
  output logic [SENSOR_W-1:0] sensor1,
  output logic [SENSOR_W-1:0] sensor2,
  output logic [SENSOR_W-1:0] sensor3,
  output logic [SENSOR_W-1:0] sensor4,
  input  logic [SENSOR_W-1:0] height_in,
  output logic [SENSOR_W-1:0] height_out,
  output logic                height_valid,
  output logic                busy,
  output logic                tmo_err,
  output logic                unstable_err
);
  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam int CW = $clog2(MAX_SCANS + 1);

  scan_state_e         state_r, state_s;
  logic [1:0]          sel_r, sel_s;
  logic [SENSOR_W-1:0] sens_r [NUM_SENSORS];
  logic [SENSOR_W-1:0] sens_s [NUM_SENSORS];
  logic [SENSOR_W-1:0] scan_h_r, scan_h_s, prev_h_r, prev_h_s, height_r, height_s;
  logic [SW-1:0]       stab_r, stab_s;
  logic [CW-1:0]       scan_r, scan_s;
  logic                valid_r, valid_s, tmo_r, tmo_s, unst_r, unst_s;
  logic                req_r, busy_r;
  logic                tmr_clear_s, tmr_en_s, tmr_expired_s;

  scan_ack_timer #(.ACK_TMO(ACK_TMO)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear_s),
    .enable  (tmr_en_s),
    .expired (tmr_expired_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and next values of every datapath register.
  always_comb begin
    state_s     = state_r;
    sel_s       = sel_r;
    sens_s      = sens_r;
    scan_h_s    = scan_h_r;
    prev_h_s    = prev_h_r;
    height_s    = height_r;
    stab_s      = stab_r;
    scan_s      = scan_r;
    valid_s     = 1'b0;
    tmo_s       = tmo_r;
    unst_s      = unst_r;
    tmr_clear_s = 1'b0;
    tmr_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          tmo_s   = 1'b0;
          unst_s  = 1'b0;
          scan_s  = {CW{1'b0}};
          stab_s  = {SW{1'b0}};
          sel_s   = SENSOR1_IDX;
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        tmr_en_s = 1'b1;
        // An ack on the expiry cycle still wins over the timeout.
        if (adc.adc_ack) begin
          sens_s[sel_r] = adc.adc_data;
          state_s       = ST_GAP;
        end else if (tmr_expired_s) begin
          sens_s[sel_r] = {SENSOR_W{1'b0}};
          tmo_s         = 1'b1;
          state_s       = ST_GAP;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_GAP: begin
        tmr_clear_s = 1'b1;
        if (sel_r != SENSOR4_IDX) begin
          sel_s   = sel_r + 2'd1;
          state_s = ST_REQ;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_CALC: begin
        scan_h_s = height_in;
        state_s  = ST_CHECK;
      end
      ST_CHECK: begin
        scan_s = (scan_r == CW'(MAX_SCANS)) ? scan_r : scan_r + CW'(1);
        if ((scan_h_r == prev_h_r) && (stab_r != {SW{1'b0}})) begin
          stab_s = (stab_r == SW'(STABLE_CNT)) ? stab_r : stab_r + SW'(1);
        end else begin
          prev_h_s = scan_h_r;
          stab_s   = SW'(1);
        end
        if (stab_s == SW'(STABLE_CNT)) begin
          height_s = prev_h_s;
          valid_s  = 1'b1;
          state_s  = ST_IDLE;
        end else if (scan_s == CW'(MAX_SCANS)) begin
          unst_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          sel_s   = SENSOR1_IDX;
          state_s = ST_REQ;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers; req/busy are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r    <= SENSOR1_IDX;
      sens_r   <= '{default: {SENSOR_W{1'b0}}};
      scan_h_r <= {SENSOR_W{1'b0}};
      prev_h_r <= {SENSOR_W{1'b0}};
      height_r <= {SENSOR_W{1'b0}};
      stab_r   <= {SW{1'b0}};
      scan_r   <= {CW{1'b0}};
      valid_r  <= 1'b0;
      tmo_r    <= 1'b0;
      unst_r   <= 1'b0;
      req_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      sel_r    <= sel_s;
      sens_r   <= sens_s;
      scan_h_r <= scan_h_s;
      prev_h_r <= prev_h_s;
      height_r <= height_s;
      stab_r   <= stab_s;
      scan_r   <= scan_s;
      valid_r  <= valid_s;
      tmo_r    <= tmo_s;
      unst_r   <= unst_s;
      req_r    <= (state_s == ST_REQ);
      busy_r   <= (state_s != ST_IDLE);
    end
  end

  assign adc.adc_req   = req_r;
  assign adc.adc_sel   = sel_r;
  assign sensor1       = sens_r[SENSOR1_IDX];
  assign sensor2       = sens_r[SENSOR2_IDX];
  assign sensor3       = sens_r[SENSOR3_IDX];
  assign sensor4       = sens_r[SENSOR4_IDX];
  assign height_out    = height_r;
  assign height_valid  = valid_r;
  assign busy          = busy_r;
  assign tmo_err       = tmo_r;
  assign unstable_err  = unst_r;
endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Directed bench for sensor_scan_ctrl: ADC responder and height-datapath model
// driven from one initial block, expected results kept in a scoreboard queue.
module tb_sensor_scan_ctrl;
  localparam int W      = 8;
  localparam int STABLE = 4;
  localparam int MAXS   = 16;
  localparam int TMO    = 15;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] height_in;
  logic [W-1:0] sensor1, sensor2, sensor3, sensor4, height_out;
  logic         height_valid, busy, tmo_err, unstable_err;

  sensor_scan_ctrl_if #(.SENSOR_W(W)) adc_bus ();

  sensor_scan_ctrl #(.SENSOR_W(W), .STABLE_CNT(STABLE), .MAX_SCANS(MAXS), .ACK_TMO(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .adc          (adc_bus),
    .sensor1      (sensor1),
    .sensor2      (sensor2),
    .sensor3      (sensor3),
    .sensor4      (sensor4),
    .height_in    (height_in),
    .height_out   (height_out),
    .height_valid (height_valid),
    .busy         (busy),
    .tmo_err      (tmo_err),
    .unstable_err (unstable_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           valid;
    logic [W-1:0] h;
    bit           tmo;
    bit           unst;
    int           vcyc;
    int           pulses;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] data_v [4];
  int           wait_v [4];
  int           tbl [$];
  bit           use_tbl, stray_ack;

  int           o_pulses, o_sel_err, o_vcyc, o_vcount;
  int           o_reqlen [4];
  logic [W-1:0] o_h, o_hout;
  logic [W-1:0] o_gap_sens [4];
  logic         o_gap_tmo [4];
  logic         o_tmo_early, o_busy_before, o_tmo, o_unst;
  bit           o_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] sens_at(input int idx);
    case (idx)
      0:       return sensor1;
      1:       return sensor2;
      2:       return sensor3;
      default: return sensor4;
    endcase
  endfunction

  // Height datapath model: mean of the non-zero samples, zero samples excluded.
  function automatic logic [W-1:0] avg_model();
    int sum = 0;
    int n   = 0;
    for (int i = 0; i < 4; i++) begin
      if (sens_at(i) != '0) begin
        sum += sens_at(i);
        n++;
      end
    end
    return (n == 0) ? '0 : W'(sum / n);
  endfunction

  // Expected latency: each sensor costs its request cycles plus one gap, plus CALC and CHECK.
  task automatic push_exp(input bit valid, input logic [W-1:0] h, input bit tmo, input bit unst,
                          input int nscans);
    exp_t e;
    int   scan_len = 2;
    for (int i = 0; i < 4; i++) begin
      scan_len += ((wait_v[i] < 0 || wait_v[i] > TMO) ? TMO + 1 : wait_v[i] + 1) + 1;
    end
    e.valid  = valid;
    e.h      = h;
    e.tmo    = tmo;
    e.unst   = unst;
    e.vcyc   = nscans * scan_len + 1;
    e.pulses = 4 * nscans;
    sb.push_back(e);
  endtask

  // One measurement: start pulse, then per-cycle ADC responses until busy drops.
  task automatic run_meas(input string name);
    exp_t       e;
    int         cyc = 0;
    int         n = 0;
    int         scan = 0;
    int         cur_sel = 0;
    logic       prev_req = 1'b0;
    logic       prev_busy = 1'b0;
    o_pulses = 0; o_sel_err = 0; o_vcyc = 0; o_vcount = 0; o_done = 1'b0;
    o_h = '0; o_busy_before = 1'b0; o_tmo_early = 1'bx;
    for (int i = 0; i < 4; i++) begin
      o_reqlen[i] = 0; o_gap_sens[i] = 'x; o_gap_tmo[i] = 1'bx;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) o_tmo_early = tmo_err;
      if (adc_bus.adc_req && !prev_req) begin
        if (int'(adc_bus.adc_sel) != (o_pulses % 4)) o_sel_err++;
        if (adc_bus.adc_sel == 2'd0) scan++;
        o_pulses++;
        n = 0;
        cur_sel = int'(adc_bus.adc_sel);
      end
      if (!adc_bus.adc_req && prev_req && scan == 1) begin
        o_gap_sens[cur_sel] = sens_at(cur_sel);
        o_gap_tmo[cur_sel]  = tmo_err;
      end
      if (adc_bus.adc_req) begin
        n++;
        if (scan == 1) o_reqlen[cur_sel] = n;
        adc_bus.adc_ack  = (wait_v[cur_sel] >= 0) && (n == wait_v[cur_sel] + 1);
        adc_bus.adc_data = adc_bus.adc_ack ? data_v[cur_sel] : 8'hEE;
      end else begin
        adc_bus.adc_ack  = stray_ack;
        adc_bus.adc_data = 8'hFF;
      end
      if (scan >= 1) begin
        height_in = use_tbl ? W'(tbl[(scan - 1 < tbl.size()) ? scan - 1 : tbl.size() - 1])
                            : avg_model();
      end
      if (height_valid) begin
        o_vcount++;
        if (o_vcount == 1) begin
          o_vcyc = cyc; o_h = height_out; o_busy_before = prev_busy;
        end
      end
      if (!busy) begin
        o_done = 1'b1;
        break;
      end
      prev_req  = adc_bus.adc_req;
      prev_busy = busy;
    end
    adc_bus.adc_ack = 1'b0;
    o_hout = height_out;
    o_tmo  = tmo_err;
    o_unst = unstable_err;
    e = sb.pop_front();
    chk({name, "_done"}, 32'(o_done), 32'd1);
    chk({name, "_tmo_cleared"}, 32'(o_tmo_early), 32'd0);
    chk({name, "_req_pulses"}, 32'(o_pulses), 32'(e.pulses));
    chk({name, "_sel_order_errs"}, 32'(o_sel_err), 32'd0);
    chk({name, "_valid_count"}, 32'(o_vcount), e.valid ? 32'd1 : 32'd0);
    chk({name, "_height_out"}, 32'(o_hout), 32'(e.h));
    chk({name, "_tmo_err"}, 32'(o_tmo), 32'(e.tmo));
    chk({name, "_unstable_err"}, 32'(o_unst), 32'(e.unst));
    if (e.valid) begin
      chk({name, "_valid_cycle"}, 32'(o_vcyc), 32'(e.vcyc));
      chk({name, "_valid_height"}, 32'(o_h), 32'(e.h));
      chk({name, "_busy_before_valid"}, 32'(o_busy_before), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; height_in = '0;
    adc_bus.adc_ack = 1'b0; adc_bus.adc_data = '0;
    use_tbl = 1'b0; stray_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {18'd0, adc_bus.adc_req, busy, height_valid, tmo_err, unstable_err,
        height_out, 1'b0}, 32'd0);
    chk("reset_sensors", {sensor1, sensor2, sensor3, sensor4}, 32'd0);
    rst = 1'b0;

    // 1: zero-wait acks, stray acks while adc_req is low.
    data_v = '{8'd100, 8'd102, 8'd98, 8'd100};
    wait_v = '{0, 0, 0, 0};
    stray_ack = 1'b1;
    push_exp(1'b1, 8'd100, 1'b0, 1'b0, STABLE);
    run_meas("t1");
    chk("t1_sensor2", 32'(o_gap_sens[1]), 32'd102);
    chk("t1_sensor4", 32'(o_gap_sens[3]), 32'd100);
    chk("t1_reqlen0", 32'(o_reqlen[0]), 32'd1);
    stray_ack = 1'b0;

    // 3: sensor index 2 never acks; the remaining three average to 302/3.
    wait_v = '{0, 0, -1, 0};
    push_exp(1'b1, 8'd100, 1'b1, 1'b0, STABLE);
    run_meas("t3");
    chk("t3_reqlen2", 32'(o_reqlen[2]), 32'(TMO + 1));
    chk("t3_sensor3_zero", 32'(o_gap_sens[2]), 32'd0);
    chk("t3_tmo_after_s3", 32'(o_gap_tmo[2]), 32'd1);
    chk("t3_tmo_before_s3", 32'(o_gap_tmo[1]), 32'd0);

    // 6: ack lands on the expiry cycle; mean of 100,77,100,100 is 94.
    data_v = '{8'd100, 8'd77, 8'd100, 8'd100};
    wait_v = '{0, TMO, 0, 0};
    push_exp(1'b1, 8'd94, 1'b0, 1'b0, STABLE);
    run_meas("t6");
    chk("t6_sensor2", 32'(o_gap_sens[1]), 32'd77);
    chk("t6_tmo_at_s2", 32'(o_gap_tmo[1]), 32'd0);
    chk("t6_reqlen1", 32'(o_reqlen[1]), 32'(TMO + 1));

    // 2: stability restarts when the height changes at scan 3.
    wait_v = '{0, 0, 0, 0};
    use_tbl = 1'b1;
    tbl = '{50, 50, 60, 60, 60, 60};
    push_exp(1'b1, 8'd60, 1'b0, 1'b0, 6);
    run_meas("t2");

    // 4: alternating heights never settle; height_out keeps 60.
    tbl = {};
    for (int i = 0; i < MAXS; i++) tbl.push_back((i % 2 == 0) ? 10 : 20);
    push_exp(1'b0, 8'd60, 1'b0, 1'b1, MAXS);
    run_meas("t4");
    use_tbl = 1'b0;

    // 5: start while busy is ignored, then reset in REQ with sel=1 aborts.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    adc_bus.adc_ack = 1'b1; adc_bus.adc_data = 8'd42;
    @(negedge clk);
    adc_bus.adc_ack = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_req_sel1", {29'd0, adc_bus.adc_req, adc_bus.adc_sel}, {29'd0, 1'b1, 2'd1});
    chk("t5_sensor1", 32'(sensor1), 32'd42);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_req_busy", {30'd0, adc_bus.adc_req, busy}, 32'd0);
    chk("t5_rst_sensors", {sensor1, sensor2, sensor3, sensor4}, 32'd0);
    chk("t5_rst_flags", {21'd0, height_out, height_valid, tmo_err, unstable_err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_idle_after_rst", {30'd0, adc_bus.adc_req, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
